// File: rtl/mux_nx1_scan_reg_if.sv
// Bus bundle for the registered N-to-1 word selector: item words in, selected word and status out.
// The master side drives the selection controls; the slave side is the selector itself.
interface mux_nx1_scan_reg_if #(
    parameter int WIDTH = 6,
    parameter int N_IN  = 8,
    parameter int SEL_W = 3
);
    logic [N_IN*WIDTH-1:0] din;
    logic [SEL_W-1:0]      sel;
    logic                  sel_load;
    logic                  scan_en;
    logic                  hold;
    logic [WIDTH-1:0]      dout;
    logic [SEL_W-1:0]      dout_idx;
    logic                  dout_valid;
    logic                  sel_err;

    modport master (
        output din, sel, sel_load, scan_en, hold,
        input  dout, dout_idx, dout_valid, sel_err
    );

    modport slave (
        input  din, sel, sel_load, scan_en, hold,
        output dout, dout_idx, dout_valid, sel_err
    );
endinterface

// File: rtl/mux_nx1_scan_reg.sv
// Registered N-to-1 word selector with range-checked index load and an auto-scan mode
// that steps through the inputs, spending DWELL cycles on each one.
module mux_nx1_scan_reg #(
    parameter int WIDTH   = 6,
    parameter int N_IN    = 8,
    parameter int SEL_W   = 3,
    parameter int DWELL   = 4,
    parameter int REVERSE = 1
) (
    input logic              clk,
    input logic              rst_n,
    mux_nx1_scan_reg_if.slave bus
);

    localparam int                CNT_W    = $clog2(DWELL + 1);
    localparam logic [SEL_W:0]    N_IN_EXT = (SEL_W + 1)'(N_IN);
    localparam logic [SEL_W-1:0]  IDX_LAST = SEL_W'(N_IN - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DWELL - 1);

    // Index-to-input mapping; with REVERSE, index 0 shows the highest input.
    function automatic logic [SEL_W-1:0] map_idx(input logic [SEL_W-1:0] k);
        if (REVERSE != 0) begin
            return IDX_LAST - k;
        end
        return k;
    endfunction

    function automatic logic [WIDTH-1:0] pick_word(
        input logic [N_IN*WIDTH-1:0] words,
        input logic [SEL_W-1:0]      w
    );
        logic [WIDTH-1:0] r;
        r = '0;
        for (int j = 0; j < N_IN; j++) begin
            if (w == SEL_W'(j)) begin
                r = words[j*WIDTH +: WIDTH];
            end
        end
        return r;
    endfunction

    logic [SEL_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic [SEL_W-1:0] dout_idx_q, dout_idx_d;
    logic             valid_q;
    logic             err_q, err_d;
    logic             sel_ok;
    logic             out_en;

    always_comb begin
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        err_d      = 1'b0;
        sel_ok     = ({1'b0, bus.sel} < N_IN_EXT);
        out_en     = bus.sel_load | ~bus.hold;
        dout_d     = dout_q;
        dout_idx_d = dout_idx_q;

        // A load wins over hold; an out-of-range load only flags the error.
        if (bus.sel_load) begin
            if (sel_ok) begin
                idx_d = bus.sel;
                cnt_d = '0;
            end else begin
                err_d = 1'b1;
            end
        end else if (!bus.hold) begin
            if (bus.scan_en) begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + SEL_W'(1);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end else begin
                cnt_d = '0;
            end
        end

        // The output follows the index written on this same edge.
        if (out_en) begin
            dout_d     = pick_word(bus.din, map_idx(idx_d));
            dout_idx_d = idx_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q      <= '0;
            cnt_q      <= '0;
            dout_q     <= '0;
            dout_idx_q <= '0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            dout_q     <= dout_d;
            dout_idx_q <= dout_idx_d;
            valid_q    <= 1'b1;
            err_q      <= err_d;
        end
    end

    assign bus.dout       = dout_q;
    assign bus.dout_idx   = dout_idx_q;
    assign bus.dout_valid = valid_q;
    assign bus.sel_err    = err_q;

endmodule
